// File: rtl/calc_i2p_sequencer_if.sv
// Signal bundle between the calculator phase sequencer and its neighbours:
// keypad token entry, infix RAM port, arranger and evaluator handshakes.
interface calc_i2p_sequencer_if #(
  parameter int DWIDTH  = 36,
  parameter int LOG_LEN = 9
);
  logic               tok_valid;
  logic [DWIDTH-1:0]  tok_data;
  logic               tok_ready;
  logic               tok_eq;
  logic               clr;

  logic               ram_en;
  logic               ram_we;
  logic [LOG_LEN-1:0] ram_addr;
  logic [DWIDTH-1:0]  ram_di;
  logic [DWIDTH-1:0]  ram_do;
  logic [LOG_LEN-1:0] top_addr;

  logic               arr_start;
  logic               arr_en;
  logic [LOG_LEN-1:0] arr_addr;
  logic [DWIDTH-1:0]  arr_do;
  logic               arr_finish;

  logic               eval_start;
  logic               eval_finish;

  logic [1:0]         phase;
  logic               err_empty;
  logic               err_overflow;

  // Sequencer side
  modport slave (
    input  tok_valid, tok_data, tok_eq, clr,
    input  ram_do, arr_en, arr_addr, arr_finish, eval_finish,
    output tok_ready, ram_en, ram_we, ram_addr, ram_di, top_addr,
    output arr_start, arr_do, eval_start, phase, err_empty, err_overflow
  );

  // Environment side: keypad, RAM, arranger and evaluator
  modport master (
    output tok_valid, tok_data, tok_eq, clr,
    output ram_do, arr_en, arr_addr, arr_finish, eval_finish,
    input  tok_ready, ram_en, ram_we, ram_addr, ram_di, top_addr,
    input  arr_start, arr_do, eval_start, phase, err_empty, err_overflow
  );
endinterface

// File: rtl/calc_i2p_sequencer.sv
// Phase sequencer for the calculator: captures tokens into the infix RAM,
// then hands the RAM read port to the arranger and finally kicks the evaluator.
module calc_i2p_sequencer #(
  parameter int DWIDTH  = 36,
  parameter int LOG_LEN = 9
) (
  input logic                  CLK_1MHz,
  input logic                  RST,
  calc_i2p_sequencer_if.slave  bus
);

  localparam int unsigned          LEN     = 1 << LOG_LEN;
  localparam logic [LOG_LEN-1:0]   PTR_MAX = LOG_LEN'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ARR  = 2'd2,
    EVAL = 2'd3
  } phase_t;

  phase_t             phase_q;
  logic [LOG_LEN-1:0] wr_ptr_q;
  logic [LOG_LEN-1:0] top_addr_q;
  logic [LOG_LEN-1:0] wr_addr_q;
  logic [DWIDTH-1:0]  wr_data_q;
  logic               wr_en_q;
  logic               arr_start_q;
  logic               eval_start_q;
  logic               err_empty_q;
  logic               err_overflow_q;

  logic               tok_ready_d;
  logic               tok_accept_d;
  logic [LOG_LEN-1:0] wr_ptr_d;

  // A token is only taken while capturing has room; clear always wins.
  always_comb begin
    tok_ready_d = 1'b0;
    if (!RST && !bus.clr) begin
      if (phase_q == IDLE) begin
        tok_ready_d = 1'b1;
      end else if (phase_q == CAPT && wr_ptr_q != PTR_MAX) begin
        tok_ready_d = 1'b1;
      end
    end
    tok_accept_d = bus.tok_valid && tok_ready_d;
    wr_ptr_d     = wr_ptr_q + 1'b1;
  end

  always_ff @(posedge CLK_1MHz) begin
    if (RST || bus.clr) begin
      phase_q        <= IDLE;
      wr_ptr_q       <= '0;
      top_addr_q     <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_en_q        <= 1'b0;
      arr_start_q    <= 1'b0;
      eval_start_q   <= 1'b0;
      err_empty_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      arr_start_q  <= 1'b0;
      eval_start_q <= 1'b0;
      err_empty_q  <= 1'b0;

      if (tok_accept_d) begin
        wr_en_q    <= 1'b1;
        wr_addr_q  <= wr_ptr_d;
        wr_data_q  <= bus.tok_data;
        wr_ptr_q   <= wr_ptr_d;
        top_addr_q <= wr_ptr_d;
      end

      case (phase_q)
        IDLE: begin
          if (tok_accept_d) begin
            err_overflow_q <= 1'b0;
            if (bus.tok_eq) begin
              phase_q     <= ARR;
              arr_start_q <= 1'b1;
            end else begin
              phase_q <= CAPT;
            end
          end else if (bus.tok_eq) begin
            err_empty_q <= 1'b1;
          end
        end
        CAPT: begin
          if (bus.tok_valid && !tok_ready_d) begin
            err_overflow_q <= 1'b1;
          end
          if (bus.tok_eq) begin
            phase_q     <= ARR;
            arr_start_q <= 1'b1;
          end
        end
        ARR: begin
          if (bus.arr_finish) begin
            phase_q      <= EVAL;
            eval_start_q <= 1'b1;
          end
        end
        EVAL: begin
          if (bus.eval_finish) begin
            phase_q  <= IDLE;
            wr_ptr_q <= '0;
          end
        end
        default: phase_q <= IDLE;
      endcase
    end
  end

  // A token taken together with "=" is still being written during the first
  // ARR cycle, so a pending write keeps the port until the RAM has captured it.
  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_di   = '0;
    if (wr_en_q) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = wr_addr_q;
      bus.ram_di   = wr_data_q;
    end else if (phase_q == ARR) begin
      bus.ram_en   = bus.arr_en;
      bus.ram_addr = bus.arr_addr;
    end
  end

  assign bus.arr_do       = (phase_q == ARR) ? bus.ram_do : '0;
  assign bus.tok_ready    = tok_ready_d;
  assign bus.top_addr     = top_addr_q;
  assign bus.arr_start    = arr_start_q;
  assign bus.eval_start   = eval_start_q;
  assign bus.phase        = phase_q;
  assign bus.err_empty    = err_empty_q;
  assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_calc_i2p_sequencer.sv
// Directed and randomized bench for calc_i2p_sequencer with a negedge RAM
// model and a queue-based record of the tokens that should have been stored.
module tb_calc_i2p_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  calc_i2p_sequencer_if #(.DWIDTH(36), .LOG_LEN(9)) bus ();

  calc_i2p_sequencer #(.DWIDTH(36), .LOG_LEN(9)) dut (
    .CLK_1MHz (clk),
    .RST      (rst),
    .bus      (bus)
  );

  // Single-port RAM sampling on negedge; every write is also logged.
  logic [35:0] mem [512];
  logic [44:0] wlog [$];
  logic [35:0] expq [$];

  always @(negedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] = bus.ram_di;
        wlog.push_back({bus.ram_addr, bus.ram_di});
      end else begin
        bus.ram_do <= mem[bus.ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [35:0] d, input logic eq);
    bus.tok_valid = v;
    bus.tok_data  = d;
    bus.tok_eq    = eq;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stored tokens must appear in order at addresses 1, 2, 3, ...
  task automatic checkLog(input string tag);
    logic [44:0] e;
    checkOutput({tag, "_count"}, 64'(wlog.size()), 64'(expq.size()));
    for (int i = 0; i < wlog.size() && i < expq.size(); i++) begin
      e = wlog[i];
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(e[44:36]), 64'(i + 1));
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(e[35:0]), 64'(expq[i]));
    end
  endtask

  function automatic logic [35:0] randTok();
    logic [35:0] t;
    t = {4'($urandom), 32'($urandom)};
    return t;
  endfunction

  logic [35:0] vec [9] = '{36'h042613333, 36'h100000171, 36'h100000150,
                           36'h041500000, 36'h100000170, 36'h04B000000,
                           36'h100000151, 36'h100000190, 36'h04B400000};

  initial begin
    int          n;
    int          a;
    logic [35:0] t;

    rst             = 1'b1;
    bus.tok_valid   = 1'b0;
    bus.tok_data    = '0;
    bus.tok_eq      = 1'b0;
    bus.clr         = 1'b0;
    bus.arr_en      = 1'b0;
    bus.arr_addr    = '0;
    bus.arr_finish  = 1'b0;
    bus.eval_finish = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_phase", 64'(bus.phase), 0);
    checkOutput("rst_top", 64'(bus.top_addr), 0);
    checkOutput("rst_ready", 64'(bus.tok_ready), 0);
    checkOutput("rst_ram_en", 64'(bus.ram_en), 0);
    checkOutput("rst_arr_start", 64'(bus.arr_start), 0);
    checkOutput("rst_ovf", 64'(bus.err_overflow), 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_ready", 64'(bus.tok_ready), 1);

    // Directed nine-token expression
    wlog.delete();
    expq.delete();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vec[i], 1'b0);
      expq.push_back(vec[i]);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("dir_phase_arr", 64'(bus.phase), 2);
    checkOutput("dir_arr_start", 64'(bus.arr_start), 1);
    checkOutput("dir_top", 64'(bus.top_addr), 9);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("dir_arr_start_off", 64'(bus.arr_start), 0);
    checkLog("dir_log");
    bus.arr_en   = 1'b1;
    bus.arr_addr = 9'd3;
    #1;
    checkOutput("dir_mux_en", 64'(bus.ram_en), 1);
    checkOutput("dir_mux_we", 64'(bus.ram_we), 0);
    checkOutput("dir_mux_addr", 64'(bus.ram_addr), 3);
    tick();
    checkOutput("dir_read3", 64'(bus.arr_do), 64'h100000150);
    bus.arr_en     = 1'b0;
    bus.arr_finish = 1'b1;
    tick();
    bus.arr_finish = 1'b0;
    checkOutput("dir_phase_eval", 64'(bus.phase), 3);
    checkOutput("dir_eval_start", 64'(bus.eval_start), 1);
    tick();
    checkOutput("dir_eval_start_off", 64'(bus.eval_start), 0);
    checkOutput("dir_eval_ram_en", 64'(bus.ram_en), 0);
    bus.eval_finish = 1'b1;
    tick();
    bus.eval_finish = 1'b0;
    checkOutput("dir_phase_idle", 64'(bus.phase), 0);
    checkOutput("dir_top_hold", 64'(bus.top_addr), 9);

    // "=" with nothing entered
    wlog.delete();
    expq.delete();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("empty_err", 64'(bus.err_empty), 1);
    checkOutput("empty_phase", 64'(bus.phase), 0);
    checkOutput("empty_arr_start", 64'(bus.arr_start), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("empty_err_off", 64'(bus.err_empty), 0);
    checkLog("empty_log");

    // Random tokens with idle gaps, then random arranger reads
    wlog.delete();
    expq.delete();
    n = $urandom_range(2, 20);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, randTok(), 1'b0);
      t = randTok();
      applyStimulus(1'b1, t, 1'b0);
      expq.push_back(t);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rnd_phase_arr", 64'(bus.phase), 2);
    checkOutput("rnd_top", 64'(bus.top_addr), 64'(n));
    applyStimulus(1'b0, '0, 1'b0);
    checkLog("rnd_log");
    for (int k = 0; k < 4; k++) begin
      a            = $urandom_range(1, n);
      bus.arr_en   = 1'b1;
      bus.arr_addr = 9'(a);
      tick();
      checkOutput($sformatf("rnd_read%0d", a), 64'(bus.arr_do), 64'(expq[a - 1]));
    end
    bus.arr_en     = 1'b0;
    bus.arr_finish = 1'b1;
    tick();
    bus.arr_finish  = 1'b0;
    bus.eval_finish = 1'b1;
    tick();
    bus.eval_finish = 1'b0;
    checkOutput("rnd_phase_idle", 64'(bus.phase), 0);

    // Fill the RAM, then offer one token too many
    wlog.delete();
    expq.delete();
    for (int i = 0; i < 511; i++) begin
      t = randTok();
      applyStimulus(1'b1, t, 1'b0);
      expq.push_back(t);
    end
    checkOutput("full_ready", 64'(bus.tok_ready), 0);
    applyStimulus(1'b1, randTok(), 1'b0);
    checkOutput("full_ovf", 64'(bus.err_overflow), 1);
    checkOutput("full_phase", 64'(bus.phase), 1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_phase_arr", 64'(bus.phase), 2);
    checkOutput("full_top", 64'(bus.top_addr), 511);
    checkOutput("full_ovf_sticky", 64'(bus.err_overflow), 1);
    applyStimulus(1'b0, '0, 1'b0);
    checkLog("full_log");
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checkOutput("clr_phase", 64'(bus.phase), 0);
    checkOutput("clr_ovf", 64'(bus.err_overflow), 0);
    checkOutput("clr_top", 64'(bus.top_addr), 0);

    // Third token arrives together with "="
    wlog.delete();
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      t = randTok();
      expq.push_back(t);
      applyStimulus(1'b1, t, (i == 2) ? 1'b1 : 1'b0);
    end
    checkOutput("eq3_phase", 64'(bus.phase), 2);
    checkOutput("eq3_arr_start", 64'(bus.arr_start), 1);
    checkOutput("eq3_top", 64'(bus.top_addr), 3);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("eq3_arr_start_off", 64'(bus.arr_start), 0);
    checkLog("eq3_log");
    bus.arr_finish = 1'b1;
    tick();
    bus.arr_finish = 1'b0;
    checkOutput("eq3_eval_start", 64'(bus.eval_start), 1);
    bus.eval_finish = 1'b1;
    tick();
    bus.eval_finish = 1'b0;
    checkOutput("eq3_phase_idle", 64'(bus.phase), 0);
    checkOutput("eq3_ready", 64'(bus.tok_ready), 1);

    // Fresh expression restarts at address 1
    wlog.delete();
    expq.delete();
    t = randTok();
    expq.push_back(t);
    applyStimulus(1'b1, t, 1'b0);
    checkOutput("new_top", 64'(bus.top_addr), 1);
    checkOutput("new_phase", 64'(bus.phase), 1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkLog("new_log");

    // Clear while the arranger owns the port
    bus.arr_en   = 1'b1;
    bus.arr_addr = 9'd1;
    #1;
    checkOutput("clrarr_ram_en_before", 64'(bus.ram_en), 1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checkOutput("clrarr_phase", 64'(bus.phase), 0);
    checkOutput("clrarr_ram_en", 64'(bus.ram_en), 0);
    checkOutput("clrarr_top", 64'(bus.top_addr), 0);
    checkOutput("clrarr_arr_do", 64'(bus.arr_do), 0);
    bus.arr_finish = 1'b1;
    tick();
    bus.arr_finish = 1'b0;
    bus.arr_en     = 1'b0;
    checkOutput("late_finish_eval", 64'(bus.eval_start), 0);
    checkOutput("late_finish_phase", 64'(bus.phase), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
